alu_exec: RTL and testbench

- Execute stage sitting directly downstream of the 8-bit register file.
- Consumes its two read ports (A/B operands) and drives its write side back: result data, write strobe and destination address.
- Also drives the register file's GE flag-set input.
- Single-cycle ops complete in one clock; MUL is an iterative shift-add taking W cycles, with a Busy back-pressure signal to the controller.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/seq_mul.sv | 76 +++++++
 rtl/alu_exec.sv | 214 +++++++++++++++++++++
 tb/tb_alu_exec.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_exec execute stage.
// Optional MUL support is selected by the ALU_MUL_EN macro in the users of this package.
package alu_pkg;

  localparam int ALU_W      = 8;       // default datapath width
  localparam int ALU_D      = 4;       // default register address width
  localparam int MUL_CYCLES = ALU_W;   // one shift-add iteration per multiplier bit

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_PASS  = 4'd8,
    OP_CMPGE = 4'd9,
    OP_MUL   = 4'd10
  } op_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier core producing the low W bits of a*b.
// One iteration per cycle; done is high during the final iteration and
// product then already includes that iteration's partial sum.
module seq_mul
  import alu_pkg::*;
#(
  parameter int W = MUL_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [W-1:0]  acc;
  logic [CW-1:0] count;
  logic [W-1:0]  acc_next;

  // Partial sum for the current iteration: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
  end

  assign done    = busy && (count == CW'(W - 1));
  assign product = acc_next;

  // Load operands on start, iterate while busy, drop the partial product on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (clear) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (done) begin
        busy <= 1'b0;
      end else begin
        busy <= 1'b1;
      end
    end else begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage between the register file read ports and its write side.
// Single-cycle ALU ops write back one cycle after acceptance; MUL runs as an
// iterative shift-add with Busy back-pressure.
// Macro ALU_MUL_EN: when defined, MUL is implemented; when undefined MUL decodes
// as NOP and no multiplier state is built.
module alu_exec
  import alu_pkg::*;
#(
  parameter int W = ALU_W,
  parameter int D = ALU_D
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         OpValid,
  input  logic [3:0]   Op,
  input  logic [W-1:0] OperandA,
  input  logic [W-1:0] OperandB,
  input  logic [D-1:0] DestIn,
  output logic         Busy,
  output logic         ResultValid,
  output logic [W-1:0] Result,
  output logic [D-1:0] DestOut,
  output logic         Carry,
  output logic         GE_FlagSet
);

  logic         accept;
  logic [W:0]   sum_w;
  logic [W:0]   shl_w;
  logic [W:0]   shr_w;
  logic [W-1:0] alu_res;
  logic         alu_carry;
  logic         alu_wr;
  logic         alu_ge;

  logic         mul_done;
  logic [W-1:0] mul_product;
  logic [D-1:0] mul_dest;
  logic         busy_next;

  // Start has priority, so a request coinciding with Start is dropped.
  assign accept = OpValid & ~Busy & ~Start;

  // Extra bit on each side catches carry-out and the last bit shifted out.
  assign sum_w = {1'b0, OperandA} + {1'b0, OperandB};
  assign shl_w = {1'b0, OperandA} << OperandB[2:0];
  assign shr_w = {OperandA, 1'b0} >> OperandB[2:0];

  // Decode the single-cycle result, carry, writeback and GE flag for the presented op.
  always_comb begin
    alu_res   = '0;
    alu_carry = Carry;
    alu_wr    = 1'b0;
    alu_ge    = 1'b0;
    case (Op)
      OP_ADD: begin
        alu_res   = sum_w[W-1:0];
        alu_carry = sum_w[W];
        alu_wr    = 1'b1;
      end
      OP_SUB: begin
        alu_res   = OperandA - OperandB;
        alu_carry = (OperandA >= OperandB);
        alu_wr    = 1'b1;
      end
      OP_AND: begin
        alu_res = OperandA & OperandB;
        alu_wr  = 1'b1;
      end
      OP_OR: begin
        alu_res = OperandA | OperandB;
        alu_wr  = 1'b1;
      end
      OP_XOR: begin
        alu_res = OperandA ^ OperandB;
        alu_wr  = 1'b1;
      end
      OP_SHL: begin
        alu_res   = shl_w[W-1:0];
        alu_carry = shl_w[W];
        alu_wr    = 1'b1;
      end
      OP_SHR: begin
        alu_res   = shr_w[W:1];
        alu_carry = shr_w[0];
        alu_wr    = 1'b1;
      end
      OP_PASS: begin
        alu_res = OperandB;
        alu_wr  = 1'b1;
      end
      OP_CMPGE: begin
        alu_ge = (OperandA >= OperandB);
      end
      default: begin
        alu_res   = '0;
        alu_carry = Carry;
        alu_wr    = 1'b0;
        alu_ge    = 1'b0;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  state_t state;
  state_t next_state;
  logic   mul_start;
  logic   mul_busy;

  // MUL sequencing state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Enter MUL_RUN on an accepted MUL; leave on done, Start, or if the core is unexpectedly idle.
  always_comb begin
    next_state = state;
    mul_start  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (Op == OP_MUL)) begin
          next_state = MUL_RUN;
          mul_start  = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      MUL_RUN: begin
        if (Start || mul_done || !mul_busy) begin
          next_state = IDLE;
        end else begin
          next_state = MUL_RUN;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture the destination register of the multiply for its delayed writeback.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mul_dest <= '0;
    end else if (mul_start) begin
      mul_dest <= DestIn;
    end else begin
      mul_dest <= mul_dest;
    end
  end

  seq_mul #(.W(W)) u_mul (
    .clk     (Clk),
    .rst     (Reset),
    .clear   (Start),
    .start   (mul_start),
    .a       (OperandA),
    .b       (OperandB),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign busy_next = (next_state == MUL_RUN);
`else
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign mul_dest    = '0;
  assign busy_next   = 1'b0;
`endif

  // Registered outputs: multiply writeback, single-cycle writeback, flags and Busy.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Busy        <= 1'b0;
      ResultValid <= 1'b0;
      Result      <= '0;
      DestOut     <= '0;
      Carry       <= 1'b0;
      GE_FlagSet  <= 1'b0;
    end else if (Start) begin
      Busy        <= 1'b0;
      ResultValid <= 1'b0;
      GE_FlagSet  <= 1'b0;
    end else begin
      Busy        <= busy_next;
      ResultValid <= 1'b0;
      GE_FlagSet  <= 1'b0;
      if (mul_done) begin
        Result      <= mul_product;
        DestOut     <= mul_dest;
        ResultValid <= 1'b1;
      end else if (accept) begin
        if (alu_wr) begin
          Result      <= alu_res;
          DestOut     <= DestIn;
          ResultValid <= 1'b1;
        end else begin
          ResultValid <= 1'b0;
        end
        Carry      <= alu_carry;
        GE_FlagSet <= alu_ge;
      end else begin
        ResultValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
// Follows the ALU_MUL_EN macro so the same bench covers both builds.
module tb_alu_exec;
  import alu_pkg::*;

`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       OpValid;
  logic [3:0] Op;
  logic [7:0] OperandA;
  logic [7:0] OperandB;
  logic [3:0] DestIn;
  logic       Busy;
  logic       ResultValid;
  logic [7:0] Result;
  logic [3:0] DestOut;
  logic       Carry;
  logic       GE_FlagSet;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Model outputs
  int         m_left = 0;
  logic [7:0] m_prod = 8'h00;
  logic [3:0] m_pdest = 4'h0;
  logic       exp_busy = 1'b0;
  logic       exp_valid = 1'b0;
  logic [7:0] exp_result = 8'h00;
  logic [3:0] exp_dest = 4'h0;
  logic       exp_carry = 1'b0;
  logic       exp_ge = 1'b0;

  alu_exec dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .OpValid     (OpValid),
    .Op          (Op),
    .OperandA    (OperandA),
    .OperandB    (OperandB),
    .DestIn      (DestIn),
    .Busy        (Busy),
    .ResultValid (ResultValid),
    .Result      (Result),
    .DestOut     (DestOut),
    .Carry       (Carry),
    .GE_FlagSet  (GE_FlagSet)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: arithmetic on integers, MUL as a countdown plus a precomputed product.
  always @(posedge Clk or posedge Reset) begin : model
    int left, a, b, n, t;
    logic v, g, c;
    logic [7:0] r;
    logic [3:0] d;
    if (Reset) begin
      m_left     <= 0;
      exp_busy   <= 1'b0;
      exp_valid  <= 1'b0;
      exp_result <= 8'h00;
      exp_dest   <= 4'h0;
      exp_carry  <= 1'b0;
      exp_ge     <= 1'b0;
    end else begin
      left = m_left; v = 1'b0; g = 1'b0;
      r = exp_result; d = exp_dest; c = exp_carry;
      a = int'(OperandA); b = int'(OperandB); n = b % 8;
      if (Start) begin
        left = 0;
      end else if (left > 0) begin
        left = left - 1;
        if (left == 0) begin v = 1'b1; r = m_prod; d = m_pdest; end
      end else if (OpValid) begin
        case (Op)
          OP_ADD:   begin t = a + b; r = 8'(t % 256); c = (t > 255); v = 1'b1; d = DestIn; end
          OP_SUB:   begin t = a - b + 256; r = 8'(t % 256); c = (a >= b); v = 1'b1; d = DestIn; end
          OP_AND:   begin r = OperandA & OperandB; v = 1'b1; d = DestIn; end
          OP_OR:    begin r = OperandA | OperandB; v = 1'b1; d = DestIn; end
          OP_XOR:   begin r = OperandA ^ OperandB; v = 1'b1; d = DestIn; end
          OP_SHL:   begin t = a * (1 << n); r = 8'(t % 256); c = (n == 0) ? 1'b0 : 1'((a >> (8 - n)) % 2); v = 1'b1; d = DestIn; end
          OP_SHR:   begin r = 8'(a / (1 << n)); c = (n == 0) ? 1'b0 : 1'((a >> (n - 1)) % 2); v = 1'b1; d = DestIn; end
          OP_PASS:  begin r = OperandB; v = 1'b1; d = DestIn; end
          OP_CMPGE: begin g = (a >= b); end
          OP_MUL:   begin
            if (MUL_ON) begin
              left = 8;
              m_prod  <= 8'((a * b) % 256);
              m_pdest <= DestIn;
            end
          end
          default: ;
        endcase
      end
      m_left     <= left;
      exp_busy   <= (left > 0);
      exp_valid  <= v;
      exp_result <= r;
      exp_dest   <= d;
      exp_carry  <= c;
      exp_ge     <= g;
    end
  end

  // Cycle-by-cycle comparison of every output against the model, sampled mid-cycle.
  always @(negedge Clk) begin
    if (chk_on) begin
      chk("busy", Busy, exp_busy);
      chk("valid", ResultValid, exp_valid);
      chk("ge", GE_FlagSet, exp_ge);
      chk("carry", Carry, exp_carry);
      chk("result", Result, exp_result);
      chk("dest", DestOut, exp_dest);
    end
  end

  // Present one set of inputs at a falling edge and advance to the next falling edge.
  task automatic cyc(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] d, input logic st);
    OpValid  = v;
    Op       = op;
    OperandA = a;
    OperandB = b;
    DestIn   = d;
    Start    = st;
    @(negedge Clk);
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int  busy_cycles;
    bit  got;
    bit  seen_rv;

    Reset = 1'b1; Start = 1'b0; OpValid = 1'b0; Op = 4'd0;
    OperandA = 8'h00; OperandB = 8'h00; DestIn = 4'h0;
    repeat (2) @(negedge Clk);
    chk_on = 1'b1;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_valid", ResultValid, 1'b0);
    chk("rst_result", Result, 8'h00);
    chk("rst_dest", DestOut, 4'h0);
    chk("rst_carry", Carry, 1'b0);
    chk("rst_ge", GE_FlagSet, 1'b0);
    Reset = 1'b0;
    cyc(1'b0, OP_NOP, 8'h00, 8'h00, 4'h0, 1'b0);

    // ADD with carry-out
    cyc(1'b1, OP_ADD, 8'hF0, 8'h20, 4'd3, 1'b0);
    chk("add_valid", ResultValid, 1'b1);
    chk("add_result", Result, 8'h10);
    chk("add_dest", DestOut, 4'd3);
    chk("add_carry", Carry, 1'b1);
    chk("model_add", exp_result, 8'h10);

    // SUB with borrow, then compare
    cyc(1'b1, OP_SUB, 8'h05, 8'h07, 4'd1, 1'b0);
    chk("sub_result", Result, 8'hFE);
    chk("sub_carry", Carry, 1'b0);
    chk("model_sub", exp_result, 8'hFE);
    cyc(1'b1, OP_CMPGE, 8'h07, 8'h05, 4'd2, 1'b0);
    chk("cmpge_ge", GE_FlagSet, 1'b1);
    chk("cmpge_valid", ResultValid, 1'b0);
    chk("cmpge_result_hold", Result, 8'hFE);
    cyc(1'b0, OP_NOP, 8'h00, 8'h00, 4'd0, 1'b0);
    chk("cmpge_pulse_end", GE_FlagSet, 1'b0);

    // Shifts: amount zero, then the test-plan case
    cyc(1'b1, OP_SHL, 8'h81, 8'h08, 4'd4, 1'b0);
    chk("shl0_result", Result, 8'h81);
    chk("shl0_carry", Carry, 1'b0);
    cyc(1'b1, OP_SHL, 8'h81, 8'h01, 4'd4, 1'b0);
    chk("shl_result", Result, 8'h02);
    chk("shl_carry", Carry, 1'b1);
    chk("model_shl_carry", exp_carry, 1'b1);

    if (MUL_ON) begin
      // MUL 13*11 with an ADD held on OpValid throughout Busy
      cyc(1'b1, OP_MUL, 8'd13, 8'd11, 4'd5, 1'b0);
      OpValid = 1'b1; Op = OP_ADD; OperandA = 8'd1; OperandB = 8'd2; DestIn = 4'd6;
      busy_cycles = 0; got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (ResultValid) begin got = 1'b1; break; end
        if (Busy) busy_cycles++;
        @(negedge Clk);
      end
      chk("mul_done_seen", got, 1'b1);
      chk("mul_busy_cycles", busy_cycles, 8);
      chk("mul_result", Result, 8'h8F);
      chk("mul_dest", DestOut, 4'd5);
      chk("mul_busy_low", Busy, 1'b0);
      chk("model_mul", exp_result, 8'h8F);
      cyc(1'b1, OP_ADD, 8'd1, 8'd2, 4'd6, 1'b0);
      chk("held_add_valid", ResultValid, 1'b1);
      chk("held_add_result", Result, 8'h03);
      chk("held_add_dest", DestOut, 4'd6);
      cyc(1'b0, OP_NOP, 8'h00, 8'h00, 4'd0, 1'b0);

      // MUL 0xFF*0xFF keeps the low byte only
      cyc(1'b1, OP_MUL, 8'hFF, 8'hFF, 4'd9, 1'b0);
      OpValid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (ResultValid) begin got = 1'b1; break; end
        @(negedge Clk);
      end
      chk("mulff_done_seen", got, 1'b1);
      chk("mulff_result", Result, 8'h01);
      chk("mulff_carry_hold", Carry, 1'b0);
    end else begin
      // Without the multiplier, MUL is a NOP
      cyc(1'b1, OP_MUL, 8'd13, 8'd11, 4'd5, 1'b0);
      chk("nomul_busy", Busy, 1'b0);
      chk("nomul_valid", ResultValid, 1'b0);
      chk("nomul_carry", Carry, 1'b1);
      chk("nomul_result", Result, 8'h02);
      cyc(1'b0, OP_NOP, 8'h00, 8'h00, 4'd0, 1'b0);
      chk("nomul_busy2", Busy, 1'b0);
      chk("nomul_valid2", ResultValid, 1'b0);
    end

    // Async reset during MUL iteration 4
    cyc(1'b1, OP_MUL, 8'hFF, 8'hFF, 4'd7, 1'b0);
    repeat (3) cyc(1'b0, OP_NOP, 8'h00, 8'h00, 4'd0, 1'b0);
    if (MUL_ON) chk("pre_reset_busy", Busy, 1'b1);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_busy", Busy, 1'b0);
    chk("mid_rst_valid", ResultValid, 1'b0);
    chk("mid_rst_result", Result, 8'h00);
    chk("mid_rst_carry", Carry, 1'b0);
    chk("mid_rst_dest", DestOut, 4'h0);
    @(negedge Clk);
    Reset = 1'b0;
    seen_rv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, OP_NOP, 8'h00, 8'h00, 4'd0, 1'b0);
      seen_rv = seen_rv | ResultValid;
    end
    chk("post_reset_no_wb", seen_rv, 1'b0);

    // Start during MUL iteration 4
    cyc(1'b1, OP_MUL, 8'hFF, 8'hFF, 4'd7, 1'b0);
    repeat (3) cyc(1'b0, OP_NOP, 8'h00, 8'h00, 4'd0, 1'b0);
    if (MUL_ON) chk("pre_start_busy", Busy, 1'b1);
    cyc(1'b0, OP_NOP, 8'h00, 8'h00, 4'd0, 1'b1);
    chk("start_busy", Busy, 1'b0);
    chk("start_valid", ResultValid, 1'b0);
    seen_rv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, OP_NOP, 8'h00, 8'h00, 4'd0, 1'b0);
      seen_rv = seen_rv | ResultValid;
    end
    chk("post_start_no_wb", seen_rv, 1'b0);
    chk("post_start_result", Result, 8'h00);

    // Randomized traffic with occasional Start and async reset pulses
    for (int i = 0; i < 2000; i++) begin
      OpValid  = ($urandom_range(0, 3) != 0);
      Op       = ($urandom_range(0, 5) == 0) ? 4'(OP_MUL) : 4'($urandom_range(0, 15));
      OperandA = 8'($urandom_range(0, 255));
      OperandB = 8'($urandom_range(0, 255));
      DestIn   = 4'($urandom_range(0, 15));
      Start    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 Reset = 1'b1;
        #1 Reset = 1'b0;
      end
      @(negedge Clk);
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
